// File: rtl/mdu_pkg.sv
// mdu_pkg: shared states, opcodes and default width for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic MDU_OP_MULT = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} mdu_state_t;
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on unsigned magnitudes
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] diff;
  // Bit WIDTH of the difference is the borrow: remainder < divisor keeps it below 2^WIDTH
  assign diff = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign rem_next = diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed Booth multiply / restoring divide writing HI/LO
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  mdu_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] acc_hi, m_ext, booth_sum;
  logic [WIDTH-1:0] acc_lo, m, a_mag, b_mag, rem_next, quo_next, quo_fix, rem_fix;
  logic q, op_r, neg_q, neg_r;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  // Upper accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow
  assign m_ext = {m[WIDTH-1], m};
  assign booth_sum = {acc_lo[0], q} == 2'b01 ? acc_hi + m_ext :
                     {acc_lo[0], q} == 2'b10 ? acc_hi - m_ext : acc_hi;
  assign quo_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(acc_hi[WIDTH-1:0]),
    .quo(acc_lo),
    .dvs(m),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m <= '0;
      q <= 1'b0;
      op_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cnt <= CW'(WIDTH);
          busy <= 1'b1;
          op_r <= op;
          q <= 1'b0;
          acc_hi <= '0;
          neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r <= a[WIDTH-1];
          if (op == MDU_OP_MULT) begin
            m <= a;
            acc_lo <= b;
            div_zero <= 1'b0;
            state <= S_MULT;
          end else if (b == '0) begin
            div_zero <= 1'b1;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            m <= b_mag;
            acc_lo <= a_mag;
            div_zero <= 1'b0;
            state <= S_DIV;
          end
        end
        S_MULT: begin
          acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          q <= acc_lo[0];
          cnt <= cnt - CW'(1);
          state <= cnt == CW'(1) ? S_FIX : S_MULT;
        end
        S_DIV: begin
          acc_hi <= {1'b0, rem_next};
          acc_lo <= quo_next;
          cnt <= cnt - CW'(1);
          state <= cnt == CW'(1) ? S_FIX : S_DIV;
        end
        S_FIX: begin
          hi <= op_r == MDU_OP_DIV ? rem_fix : acc_hi[WIDTH-1:0];
          lo <= op_r == MDU_OP_DIV ? quo_fix : acc_lo;
          done <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a done-driven scoreboard monitor
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [64:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (reset && done) begin
      logic [64:0] e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got hi=%h lo=%h dz=%b, want no result", hi, lo, div_zero);
      end else begin
        e = sb.pop_front();
        if ({hi, lo, div_zero} !== e) begin
          n_err++;
          $display("FAIL result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, e[64:33], e[32:1], e[0]);
        end
      end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] eh, input logic [31:0] el, input logic edz, input int inject);
    int n;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back({eh, el, edz});
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    chk("busy_after_e0", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      if (n + 1 == inject) begin
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
      end
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end
    chk("latency", 64'(n), (o && y == 0) ? 64'd0 : 64'd33);
    @(posedge clock); #1;
    chk("done_pulse_end", 64'(done), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {29'd0, busy, done, div_zero, hi | lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    run(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    run(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
    run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    run(1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 0);
    run(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);
    run(1'b1, 32'd5, 32'd0, 32'h00000000, 32'h80000000, 1'b1, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("div_zero_holds", {31'd0, div_zero, hi}, {31'd0, 1'b1, 32'h00000000});
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd6; b = 32'hFFFFFFF9;
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0});
    @(posedge clock); #1;
    start = 1'b0;
    chk("div_zero_cleared", 64'(div_zero), 64'd0);
    repeat (40) @(posedge clock);
    run(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 5);
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset", {29'd0, busy, done, div_zero, hi | lo}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    run(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 0);
    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle signed multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the control unit. The control unit raises `start` with an operation code. This block iterates on the two register-file operands, writes the HI/LO pair, and signals `done` so the control unit can leave its wait state.
- Implements `mult` and `div`. `mfhi`/`mflo` read `hi`/`lo` directly.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 1: 0 = mult, 1 = div; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (signed); sampled with `start`.
- `b` in WIDTH: multiplier or divisor (signed); sampled with `start`.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid and final.
- `div_zero` out 1: last div had `b`=0; holds until the next accepted `start`.
- `hi` out WIDTH: product[2W-1:W] for mult, remainder for div.
- `lo` out WIDTH: product[W-1:0] for mult, quotient for div.

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - `start`=1, `op`=0 → MULT.
  - `start`=1, `op`=1, `b`≠0 → DIV.
  - `start`=1, `op`=1, `b`=0 → DONE, with `div_zero` set, `hi`/`lo` unchanged.
- On accept, operands are latched, `div_zero` is cleared (or set), and the iteration counter is loaded with WIDTH.
- MULT: radix-2 Booth on the signed operands, one step per cycle, WIDTH steps, then → FIX.
- DIV: restoring division on the magnitudes, one quotient bit per cycle, WIDTH steps, then → FIX.
- FIX writes `hi`/`lo`, then → DONE:
  - mult: full 2·WIDTH-bit signed product.
  - div: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Arithmetic is two's complement with wrap.
  - -2^(W-1) / -1 gives `lo`=0x80000000 and `hi`=0, with no flag.
  - -2^(W-1) × -2^(W-1) gives `hi`=0x40000000, `lo`=0.
- `hi`/`lo` change only in FIX and reset. They hold their values across idle cycles and across divide-by-zero.
- `start` while `busy`=1 is ignored, with no queueing. `start` during the DONE cycle is also ignored; the control unit must reassert it.
- `a`/`b`/`op` may change freely after the accepting edge.
- Reset, asserted at any time including mid-operation:
  - state → IDLE, counter → 0.
  - `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0.
  - The in-flight result is discarded.

## Timing
- Edge E0 is the edge that samples `start`.
- mult/div with `b`≠0:
  - `busy`=1 from E0.
  - Iterations occur on E1..E_WIDTH.
  - FIX occurs at E_(WIDTH+1), when `hi`/`lo` update and `done` rises.
  - `busy` falls and `done` falls at E_(WIDTH+2).
- Latency: `done` is high in the cycle after E_(WIDTH+1), i.e. 33 edges after E0 for WIDTH=32.
- div by zero: `done` and `div_zero` are high after E0. `busy`=1 for that single cycle only. `done` falls at E1.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Structure
- Package `mdu_pkg`:
  - state enum `mdu_state_t`.
  - constants `MDU_OP_MULT`=1'b0 and `MDU_OP_DIV`=1'b1.
  - default `MDU_WIDTH`=32.
- Counter width is $clog2(WIDTH)+1.
- One sub-module, `mdu_div_step`: combinational single restoring step. It takes remainder, quotient, and divisor, and returns the next remainder and quotient. The unit instantiates it once.

## Test plan
- mult `a`=7, `b`=-3 → at E33: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` for one cycle, `div_zero`=0.
- mult `a`=`b`=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- div `a`=-7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- div `a`=0x80000000, `b`=-1 → `lo`=0x80000000, `hi`=0.
- div `a`=5, `b`=0 → `done` and `div_zero` high the cycle after E0; `hi`/`lo` keep their prior values.
  - A following mult clears `div_zero` at its accept edge.
- During a mult (`a`=3, `b`=4):
  - A `start` for div 9/3 at E5 is ignored, and the result is `lo`=12.
  - Dropping `reset` low at E10 makes every output 0 immediately. After release, a new mult 2×2 gives `lo`=4.
